// File: rtl/gf_pkg.sv
// Shared GF(2^M) definitions for the row-elimination PE.
//   GF_M / GF_POLY : default field degree and reduction polynomial
//   GF_W           : widest element the arithmetic helpers handle
//   pe_state_t     : PE pivot state (EMPTY, CAPT, FULL, DRAIN)
//   gf_reduce      : reduce a carry-less product modulo poly
//   gf_mul         : carry-less multiply followed by reduction
package gf_pkg;

  localparam int GF_M = 8;
  localparam logic [GF_M:0] GF_POLY = 9'h11B;
  localparam int GF_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_CAPT,
    ST_FULL,
    ST_DRAIN
  } pe_state_t;

  // Clears every product bit at or above degree m by folding in poly,
  // highest degree first so each fold only touches lower bits.
  function automatic logic [GF_W-1:0] gf_reduce(input logic [2*GF_W-2:0] prod,
                                                input int m,
                                                input logic [GF_W:0] poly);
    logic [2*GF_W-2:0] r;
    r = prod;
    for (int i = 2*GF_W-2; i >= 0; i--) begin
      if (i >= m && r[i]) r = r ^ ((2*GF_W-1)'(poly) << (i - m));
    end
    return r[GF_W-1:0];
  endfunction

  function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a,
                                             input logic [GF_W-1:0] b,
                                             input int m,
                                             input logic [GF_W:0] poly);
    logic [2*GF_W-2:0] prod;
    prod = '0;
    for (int i = 0; i < GF_W; i++) begin
      if (b[i]) prod = prod ^ ((2*GF_W-1)'(a) << i);
    end
    return gf_reduce(prod, m, poly);
  endfunction

endpackage

// File: rtl/gf_inv.sv
// Combinational GF(2^M) inverse by Fermat: inv = a^(2^M-2).
//   a   : element to invert
//   inv : its inverse (0 maps to 0)
// Built as a chain of squarings a^2, a^4, ... a^(2^(M-1)) whose running
// product is a^(2+4+...+2^(M-1)) = a^(2^M-2).
module gf_inv
  import gf_pkg::*;
#(
  parameter int M = GF_M,
  parameter logic [M:0] POLY = (M+1)'(GF_POLY)
) (
  input  logic [M-1:0] a,
  output logic [M-1:0] inv
);

  function automatic logic [M-1:0] mulf(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [GF_W-1:0] r;
    r = gf_mul(GF_W'(x), GF_W'(y), M, (GF_W+1)'(POLY));
    return r[M-1:0];
  endfunction

  logic [M-1:0] sq  [M];
  logic [M-1:0] acc [M];

  assign sq[0]  = a;
  assign acc[0] = M'(1);

  genvar gi;
  generate
    for (gi = 1; gi < M; gi++) begin : g_chain
      assign sq[gi]  = mulf(sq[gi-1], sq[gi-1]);
      assign acc[gi] = mulf(acc[gi-1], sq[gi]);
    end
  endgenerate

  assign inv = acc[M-1];

endmodule

// File: rtl/gf_row_elim_pe.sv
// Row-serial Gaussian-elimination PE over GF(2^M), one pivot column.
//   in_*      : incoming rows, lead element first, LEN elements per row
//   out_*     : reduced rows (lead dropped), LEN-1 elements per row
//   drain_req : request to emit and clear the held pivot row
//   piv_*     : pivot row stream (1 followed by LEN-1 stored elements)
//   drain_done: one-cycle pulse at the end of a drain
//   has_piv   : a pivot row is held
//   row_err   : sticky, a row's in_last did not line up with LEN
//   rst       : asynchronous, active low
module gf_row_elim_pe
  import gf_pkg::*;
#(
  parameter int M = GF_M,
  parameter logic [M:0] POLY = (M+1)'(GF_POLY),
  parameter int LEN = 16,
  parameter int PIPE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data,
  output logic         out_last,
  input  logic         drain_req,
  output logic         piv_valid,
  input  logic         piv_ready,
  output logic [M-1:0] piv_data,
  output logic         piv_last,
  output logic         drain_done,
  output logic         has_piv,
  output logic         row_err
);

  localparam int IW = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [IW-1:0] J_LAST = IW'(LEN-1);

  function automatic logic [M-1:0] mulf(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [GF_W-1:0] r;
    r = gf_mul(GF_W'(x), GF_W'(y), M, (GF_W+1)'(POLY));
    return r[M-1:0];
  endfunction

  pe_state_t state_reg, state_next;
  logic          run_reg, drain_pend_reg, drain_done_reg, row_err_reg;
  logic [IW-1:0] col_reg, dcnt_reg;
  logic [M-1:0]  lead_reg, inv_reg, inv_comb;
  logic [M-1:0]  pbuf [LEN-1];

  // Pipeline after the multiplier: valid, emit (goes to out_*),
  // write (capture into pbuf), last, data, buffer index.
  logic [PIPE-1:0] pv_reg, pe_reg, pw_reg, pl_reg;
  logic [M-1:0]    pd_reg [PIPE];
  logic [IW-1:0]   pi_reg [PIPE];

  logic          stall, pipe_busy, acc, lead_beat, push, honour, piv_fire, drain_end;
  logic [IW-1:0] rd_addr;
  logic [M-1:0]  prd, mul_a, mul_b, prod, beat_data;

  gf_inv #(.M(M), .POLY(POLY)) u_inv (.a(in_data), .inv(inv_comb));

  assign out_valid = pv_reg[PIPE-1] && pe_reg[PIPE-1];
  assign out_data  = pd_reg[PIPE-1];
  assign out_last  = out_valid && pl_reg[PIPE-1];
  assign stall     = out_valid && !out_ready;
  assign pipe_busy = |pv_reg;
  assign lead_beat = (col_reg == '0);

  // A pending drain only blocks the start of a new row, so a row already
  // in flight can finish before the drain is taken.
  assign in_ready  = run_reg && !stall && !(drain_pend_reg && lead_beat) && (state_reg != ST_DRAIN);
  assign acc       = in_valid && in_ready;
  assign push      = acc && !lead_beat;
  assign honour    = drain_pend_reg && lead_beat && !pipe_busy && (state_reg != ST_DRAIN);

  assign piv_valid = (state_reg == ST_DRAIN);
  assign piv_fire  = piv_valid && piv_ready;
  assign drain_end = piv_fire && (dcnt_reg == J_LAST);
  assign piv_last  = piv_valid && (dcnt_reg == J_LAST);
  assign piv_data  = !piv_valid ? '0 : (dcnt_reg == '0) ? M'(1) : prd;

  assign has_piv    = (state_reg == ST_FULL) || (state_reg == ST_DRAIN);
  assign drain_done = drain_done_reg;
  assign row_err    = row_err_reg;

  // Single read port: the drain counter owns it during DRAIN, the column
  // counter otherwise (no input is accepted while draining).
  always_comb begin
    rd_addr = '0;
    if (state_reg == ST_DRAIN) begin
      if (dcnt_reg != '0) rd_addr = dcnt_reg - 1'b1;
    end else if (!lead_beat) begin
      rd_addr = col_reg - 1'b1;
    end
    // Captured elements land in pbuf only at the pipeline exit; forward
    // any still in flight so a short row right after capture sees them.
    prd = pbuf[rd_addr];
    for (int k = 0; k < PIPE; k++) begin
      if (pv_reg[k] && pw_reg[k] && pi_reg[k] == rd_addr) prd = pd_reg[k];
    end
  end

  always_comb begin
    mul_a = (state_reg == ST_CAPT) ? in_data : lead_reg;
    mul_b = (state_reg == ST_CAPT) ? inv_reg : prd;
    prod  = mulf(mul_a, mul_b);
    case (state_reg)
      ST_CAPT: beat_data = prod;
      ST_FULL: beat_data = in_data ^ prod;
      default: beat_data = in_data;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      // A lone lead carrying in_last is a malformed row; it must not open a capture.
      ST_EMPTY: if (acc && lead_beat && in_data != '0 && !in_last) state_next = ST_CAPT;
      ST_CAPT:  if (acc && in_last) state_next = ST_FULL;
      ST_FULL:  if (honour) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_end) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_EMPTY;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_reg        <= 1'b0;
      drain_pend_reg <= 1'b0;
      drain_done_reg <= 1'b0;
      row_err_reg    <= 1'b0;
      col_reg        <= '0;
      dcnt_reg       <= '0;
      lead_reg       <= '0;
      inv_reg        <= '0;
    end else begin
      run_reg        <= 1'b1;
      drain_done_reg <= (honour && state_reg != ST_FULL) || drain_end;
      if (honour) drain_pend_reg <= 1'b0;
      else if (drain_req && state_reg != ST_DRAIN) drain_pend_reg <= 1'b1;
      if (acc) begin
        col_reg <= (in_last || col_reg == J_LAST) ? '0 : col_reg + 1'b1;
        if (in_last != (col_reg == J_LAST)) row_err_reg <= 1'b1;
        if (lead_beat) begin
          lead_reg <= in_data;
          inv_reg  <= inv_comb;
        end
      end
      if (piv_fire) dcnt_reg <= (dcnt_reg == J_LAST) ? '0 : dcnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv_reg <= '0;
      pe_reg <= '0;
      pw_reg <= '0;
      pl_reg <= '0;
      for (int k = 0; k < PIPE; k++) begin
        pd_reg[k] <= '0;
        pi_reg[k] <= '0;
      end
    end else if (!stall) begin
      pv_reg[0] <= push;
      pe_reg[0] <= (state_reg != ST_CAPT);
      pw_reg[0] <= (state_reg == ST_CAPT);
      pl_reg[0] <= (col_reg == J_LAST);
      pd_reg[0] <= beat_data;
      pi_reg[0] <= rd_addr;
      for (int k = 1; k < PIPE; k++) begin
        pv_reg[k] <= pv_reg[k-1];
        pe_reg[k] <= pe_reg[k-1];
        pw_reg[k] <= pw_reg[k-1];
        pl_reg[k] <= pl_reg[k-1];
        pd_reg[k] <= pd_reg[k-1];
        pi_reg[k] <= pi_reg[k-1];
      end
    end
  end

  // Pivot buffer write port at the pipeline exit; contents need no reset.
  always_ff @(posedge clk) begin
    if (pv_reg[PIPE-1] && pw_reg[PIPE-1] && !stall) pbuf[pi_reg[PIPE-1]] <= pd_reg[PIPE-1];
  end

endmodule

// File: tb/tb_gf_row_elim_pe.sv
module tb_gf_row_elim_pe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       drain_req = 1'b0, piv_ready = 1'b1;
  logic       in_ready, out_valid, out_last, piv_valid, piv_last, drain_done, has_piv, row_err;
  logic [7:0] out_data, piv_data;

  gf_row_elim_pe #(.M(8), .POLY(9'h11B), .LEN(4), .PIPE(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .drain_req(drain_req),
    .piv_valid(piv_valid), .piv_ready(piv_ready), .piv_data(piv_data), .piv_last(piv_last),
    .drain_done(drain_done), .has_piv(has_piv), .row_err(row_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dd_cnt = 0;
  logic tog_en = 1'b0;
  logic [8:0] out_q[$];
  logic [8:0] piv_q[$];

  typedef struct {
    logic [31:0] row;
    int          n_out;
    logic [23:0] exp_out;
    logic        exp_piv;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Transfers are sampled on the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) out_q.push_back({out_last, out_data});
      if (piv_valid && piv_ready) piv_q.push_back({piv_last, piv_data});
      if (drain_done) dd_cnt++;
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready) begin
          errors++;
          $display("FAIL stall_in_ready got=1 expected=0");
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (tog_en) out_ready = ~out_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 300) begin n++; @(negedge clk); end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout data=%0h", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_row(input logic [31:0] r);
    logic [31:0] v;
    v = r;
    send_beat(v[31:24], 1'b0);
    send_beat(v[23:16], 1'b0);
    send_beat(v[15:8],  1'b0);
    send_beat(v[7:0],   1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (out_q.size() < n && t < 300) begin t++; @(posedge clk); end
    idle(4);
    chk("out_count", out_q.size(), n);
  endtask

  task automatic drain_seq(input logic [31:0] exp_piv, input int n, input logic hold);
    int dd0, t;
    logic [31:0] e;
    e = exp_piv;
    dd0 = dd_cnt;
    piv_q.delete();
    piv_ready = !hold;
    drain_req = 1'b1;
    @(posedge clk); #1;
    drain_req = 1'b0;
    if (hold) begin
      repeat (6) @(negedge clk);
      chk("hold_piv_valid", piv_valid, 1);
      chk("hold_piv_data", piv_data, 8'h01);
      chk("hold_piv_count", piv_q.size(), 0);
      t = 0;
      while (piv_q.size() < n && t < 100) begin
        t++;
        @(posedge clk); #1;
        piv_ready = ~piv_ready;
      end
      piv_ready = 1'b1;
    end
    t = 0;
    while (dd_cnt == dd0 && t < 100) begin t++; @(posedge clk); end
    idle(3);
    chk("drain_done_pulses", dd_cnt - dd0, 1);
    chk("piv_count", piv_q.size(), n);
    for (int i = 0; i < n && i < piv_q.size(); i++) begin
      chk($sformatf("piv_beat%0d", i), piv_q[i], {(i == n-1), e[31-8*i -: 8]});
    end
    chk("has_piv_after_drain", has_piv, 0);
  endtask

  logic [8:0] exp5 [9];

  initial begin
    vecs[0] = '{row: 32'h00070809, n_out: 3, exp_out: 24'h070809, exp_piv: 1'b0};
    vecs[1] = '{row: 32'h53530100, n_out: 0, exp_out: 24'h000000, exp_piv: 1'b1};
    vecs[2] = '{row: 32'h01020304, n_out: 0, exp_out: 24'h000000, exp_piv: 1'b1};
    vecs[3] = '{row: 32'h02010001, n_out: 3, exp_out: 24'h050609, exp_piv: 1'b1};
    exp5 = '{9'h005, 9'h006, 9'h109, 9'h006, 9'h005, 9'h10C, 9'h00A, 9'h00B, 9'h10C};

    // Reset mid-row: start a capture row, then pull reset
    idle(3);
    rst = 1'b1;
    idle(2);
    send_beat(8'h05, 1'b0);
    send_beat(8'h11, 1'b0);
    rst = 1'b0;
    #1;
    chk("reset_outputs",
        {in_ready, out_valid, out_data, out_last, piv_valid, piv_data, piv_last, drain_done, has_piv, row_err}, 0);
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready_during_release", in_ready, 0);
    @(negedge clk);
    chk("in_ready_after_release", in_ready, 1);
    chk("row_err_after_reset", row_err, 0);
    @(posedge clk); #1;

    // Table vectors; the first pivot is drained between capture and the next pivot
    for (int i = 0; i < 4; i++) begin
      logic [23:0] eo;
      if (i == 2) drain_seq(32'h0101CA00, 4, 1'b0);
      out_q.delete();
      send_row(vecs[i].row);
      wait_out(vecs[i].n_out);
      eo = vecs[i].exp_out;
      for (int k = 0; k < vecs[i].n_out && k < out_q.size(); k++) begin
        chk($sformatf("vec%0d_out%0d", i, k), out_q[k], {(k == 2), eo[23-8*k -: 8]});
      end
      chk($sformatf("vec%0d_has_piv", i), has_piv, vecs[i].exp_piv);
    end

    // Three back-to-back rows against a toggling out_ready
    out_q.delete();
    tog_en = 1'b1;
    send_row(32'h02010001);
    send_row(32'h03000000);
    send_row(32'h000A0B0C);
    wait_out(9);
    tog_en = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 9 && k < out_q.size(); k++) begin
      chk($sformatf("b2b_out%0d", k), out_q[k], exp5[k]);
    end
    drain_seq(32'h01020304, 4, 1'b1);

    // Malformed row, then a good row, then a drain with nothing held
    out_q.delete();
    send_beat(8'h00, 1'b0);
    send_beat(8'h05, 1'b1);
    wait_out(1);
    if (out_q.size() > 0) chk("err_row_out", out_q[0], 9'h005);
    chk("row_err_set", row_err, 1);
    out_q.delete();
    send_row(32'h00070809);
    wait_out(3);
    for (int k = 0; k < 3 && k < out_q.size(); k++) begin
      chk($sformatf("after_err_out%0d", k), out_q[k], {(k == 2), 8'h07 + 8'(k)});
    end
    chk("row_err_sticky", row_err, 1);
    drain_seq(32'h00000000, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
